// File: rtl/snake_pkg.sv
// Shared types and constants for the snake body tracker.
// Optional build macro: SNAKE_WALL_WRAP_EN (wrap the head around the playfield edges).
package snake_pkg;

   // Movement direction as issued by the game controller
   typedef enum logic [1:0] {
      DIR_UP    = 2'd0,
      DIR_RIGHT = 2'd1,
      DIR_DOWN  = 2'd2,
      DIR_LEFT  = 2'd3
   } dir_t;

   // Step sequencer states
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_CHECK  = 2'd1,
      ST_COMMIT = 2'd2,
      ST_DEAD   = 2'd3
   } state_t;

   localparam int DEF_GRID_W     = 20;
   localparam int DEF_GRID_H     = 15;
   localparam int DEF_TILE_SHIFT = 5;
   localparam int DEF_MAX_LEN    = 63;
   localparam int DEF_INIT_LEN   = 3;
   localparam int DEF_INIT_X     = 1;
   localparam int DEF_INIT_Y     = 1;
   localparam int DEF_PXL_W      = 11;

   // Bits needed to hold a life counter / length in 0..max_len
   function automatic int life_width(input int max_len);
      return $clog2(max_len + 1);
   endfunction

   // Bits needed to index n items (at least one bit)
   function automatic int coord_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/snake_body_tracker_if.sv
// Control/draw bus between the game controller, the tracker and the drawing mux.
// Optional build macro: SNAKE_WALL_WRAP_EN (no effect on the bus itself).
interface snake_body_tracker_if
   import snake_pkg::*;
#(
   parameter int PXL_W = DEF_PXL_W,
   parameter int LEN_W = 6
);
   logic             restart;
   logic             step;
   dir_t             dir;
   logic             grow;
   logic [PXL_W-1:0] pxl_x;
   logic [PXL_W-1:0] pxl_y;
   logic             draw_body;
   logic             draw_head;
   logic             busy;
   logic             step_done;
   logic             gameover;
   logic [LEN_W-1:0] length;

   // Controller side
   modport master (
      output restart, step, dir, grow, pxl_x, pxl_y,
      input  draw_body, draw_head, busy, step_done, gameover, length
   );

   // Tracker side
   modport slave (
      input  restart, step, dir, grow, pxl_x, pxl_y,
      output draw_body, draw_head, busy, step_done, gameover, length
   );
endinterface

// File: rtl/snake_next_head.sv
// Combinational next head coordinate plus off-grid flag.
// Optional build macro: SNAKE_WALL_WRAP_EN -- when defined the head wraps at the
// edges and off_grid is never raised; otherwise leaving the grid flags off_grid.
// On off_grid the coordinate is left unchanged so it always indexes a valid cell.
module snake_next_head
   import snake_pkg::*;
#(
   parameter int GRID_W = DEF_GRID_W,
   parameter int GRID_H = DEF_GRID_H,
   parameter int X_W    = 5,
   parameter int Y_W    = 4
)(
   input  logic [X_W-1:0] x,
   input  logic [Y_W-1:0] y,
   input  dir_t           dir,
   output logic [X_W-1:0] nx,
   output logic [Y_W-1:0] ny,
   output logic           off_grid
);
   localparam logic [X_W-1:0] X_MAX = X_W'(GRID_W - 1);
   localparam logic [Y_W-1:0] Y_MAX = Y_W'(GRID_H - 1);

   // One-cell move in the requested direction with edge handling
   always_comb begin
      nx       = x;
      ny       = y;
      off_grid = 1'b0;
      unique case (dir)
         DIR_UP: begin
            if (y == '0) begin
`ifdef SNAKE_WALL_WRAP_EN
               ny = Y_MAX;
`else
               off_grid = 1'b1;
`endif
            end else begin
               ny = y - 1'b1;
            end
         end
         DIR_RIGHT: begin
            if (x == X_MAX) begin
`ifdef SNAKE_WALL_WRAP_EN
               nx = '0;
`else
               off_grid = 1'b1;
`endif
            end else begin
               nx = x + 1'b1;
            end
         end
         DIR_DOWN: begin
            if (y == Y_MAX) begin
`ifdef SNAKE_WALL_WRAP_EN
               ny = '0;
`else
               off_grid = 1'b1;
`endif
            end else begin
               ny = y + 1'b1;
            end
         end
         DIR_LEFT: begin
            if (x == '0) begin
`ifdef SNAKE_WALL_WRAP_EN
               nx = X_MAX;
`else
               off_grid = 1'b1;
`endif
            end else begin
               nx = x - 1'b1;
            end
         end
      endcase
   end
endmodule

// File: rtl/snake_body_tracker.sv
// Snake body tracker: occupancy grid of life counters, head position, length,
// collision detection and registered per-pixel draw flags.
// Optional build macro: SNAKE_WALL_WRAP_EN (handled in snake_next_head).
// Each cell holds the number of further non-growing steps before it empties;
// a plain step decrements every live cell, a growing step leaves them alone.
module snake_body_tracker
   import snake_pkg::*;
#(
   parameter int GRID_W     = DEF_GRID_W,
   parameter int GRID_H     = DEF_GRID_H,
   parameter int TILE_SHIFT = DEF_TILE_SHIFT,
   parameter int MAX_LEN    = DEF_MAX_LEN,
   parameter int INIT_LEN   = DEF_INIT_LEN,
   parameter int INIT_X     = DEF_INIT_X,
   parameter int INIT_Y     = DEF_INIT_Y,
   parameter int PXL_W      = DEF_PXL_W
)(
   input  logic                 clk,
   input  logic                 reset,
   snake_body_tracker_if.slave  bus
);
   localparam int LEN_W    = life_width(MAX_LEN);
   localparam int X_W      = coord_width(GRID_W);
   localparam int Y_W      = coord_width(GRID_H);
   localparam int CELLS    = GRID_W * GRID_H;
   localparam int IDX_W    = coord_width(CELLS);
   localparam int INIT_IDX = INIT_Y * GRID_W + INIT_X;
   localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_LEN);
   localparam logic [LEN_W-1:0] LEN_INIT = LEN_W'(INIT_LEN);

   state_t           state_q, state_d;
   dir_t             dir_q, dir_d;
   logic             grow_q, grow_d;
   logic             gameover_q, gameover_d;
   logic [X_W-1:0]   hx_q, hx_d;
   logic [Y_W-1:0]   hy_q, hy_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [LEN_W-1:0] life_q [CELLS];
   logic [LEN_W-1:0] life_d [CELLS];
   logic             draw_body_q, draw_body_d;
   logic             draw_head_q, draw_head_d;

   logic             clear;
   logic [X_W-1:0]   nx;
   logic [Y_W-1:0]   ny;
   logic             off_grid;
   logic [IDX_W-1:0] tgt_idx;
   logic [LEN_W-1:0] tgt_life;
   logic             grow_eff;
   logic             collide;

   logic [PXL_W-1:0] pix_cx, pix_cy;
   logic             pix_in;
   logic [IDX_W-1:0] pix_idx;
   logic [LEN_W-1:0] pix_life;

   // Restart behaves exactly like reset
   assign clear = reset | bus.restart;

   snake_next_head #(
      .GRID_W (GRID_W),
      .GRID_H (GRID_H),
      .X_W    (X_W),
      .Y_W    (Y_W)
   ) u_next_head (
      .x        (hx_q),
      .y        (hy_q),
      .dir      (dir_q),
      .nx       (nx),
      .ny       (ny),
      .off_grid (off_grid)
   );

   // Target cell lookup and collision rule; a saturated snake treats grow as
   // absent both here and in COMMIT so the two decisions stay consistent
   always_comb begin
      tgt_idx  = IDX_W'(int'(ny) * GRID_W + int'(nx));
      tgt_life = life_q[tgt_idx];
      grow_eff = (grow_q | bus.grow) & (len_q < LEN_MAX);
      collide  = off_grid |
                 (!grow_eff && (tgt_life > LEN_W'(1))) |
                 (grow_eff && (tgt_life != '0));
   end

   // State register
   always_ff @(posedge clk) begin
      if (clear) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic; steps outside IDLE are simply not looked at
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:   if (bus.step) state_d = ST_CHECK;
         ST_CHECK:  state_d = collide ? ST_DEAD : ST_COMMIT;
         ST_COMMIT: state_d = ST_IDLE;
         ST_DEAD:   state_d = ST_DEAD;
         default:   state_d = ST_IDLE;
      endcase
   end

   // Status and draw outputs
   always_comb begin
      bus.busy      = (state_q != ST_IDLE);
      bus.step_done = (state_q == ST_COMMIT);
      bus.gameover  = gameover_q;
      bus.length    = len_q;
      bus.draw_body = draw_body_q;
      bus.draw_head = draw_head_q;
   end

   // Datapath next values: direction capture, grow latch, head, length, grid
   always_comb begin
      dir_d      = dir_q;
      grow_d     = grow_q | bus.grow;
      gameover_d = gameover_q;
      hx_d       = hx_q;
      hy_d       = hy_q;
      len_d      = len_q;
      for (int i = 0; i < CELLS; i++) life_d[i] = life_q[i];

      if (state_q == ST_IDLE && bus.step) dir_d = bus.dir;
      if (state_q == ST_CHECK && collide) gameover_d = 1'b1;

      if (state_q == ST_COMMIT) begin
         grow_d = 1'b0;
         hx_d   = nx;
         hy_d   = ny;
         if (grow_eff) len_d = len_q + 1'b1;
         for (int i = 0; i < CELLS; i++) begin
            if (tgt_idx == IDX_W'(i)) begin
               life_d[i] = grow_eff ? (len_q + 1'b1) : len_q;
            end else if (!grow_eff && life_q[i] != '0) begin
               life_d[i] = life_q[i] - 1'b1;
            end
         end
      end
   end

   // Datapath registers; reset/restart wins over any step in flight
   always_ff @(posedge clk) begin
      if (clear) begin
         dir_q      <= DIR_UP;
         grow_q     <= 1'b0;
         gameover_q <= 1'b0;
         hx_q       <= X_W'(INIT_X);
         hy_q       <= Y_W'(INIT_Y);
         len_q      <= LEN_INIT;
         for (int i = 0; i < CELLS; i++) life_q[i] <= (i == INIT_IDX) ? LEN_INIT : '0;
      end else begin
         dir_q      <= dir_d;
         grow_q     <= grow_d;
         gameover_q <= gameover_d;
         hx_q       <= hx_d;
         hy_q       <= hy_d;
         len_q      <= len_d;
         for (int i = 0; i < CELLS; i++) life_q[i] <= life_d[i];
      end
   end

   // Pixel-to-cell lookup for the drawing mux
   always_comb begin
      pix_cx      = bus.pxl_x >> TILE_SHIFT;
      pix_cy      = bus.pxl_y >> TILE_SHIFT;
      pix_in      = (pix_cx < PXL_W'(GRID_W)) && (pix_cy < PXL_W'(GRID_H));
      pix_idx     = pix_in ? IDX_W'(int'(pix_cy) * GRID_W + int'(pix_cx)) : '0;
      pix_life    = life_q[pix_idx];
      draw_head_d = pix_in && (int'(pix_cx) == int'(hx_q)) && (int'(pix_cy) == int'(hy_q));
      draw_body_d = pix_in && (pix_life != '0) && !draw_head_d;
   end

   // Registered draw flags
   always_ff @(posedge clk) begin
      if (clear) begin
         draw_body_q <= 1'b0;
         draw_head_q <= 1'b0;
      end else begin
         draw_body_q <= draw_body_d;
         draw_head_q <= draw_head_d;
      end
   end

endmodule

// File: tb/tb_snake_body_tracker.sv
// Self-checking bench for snake_body_tracker. The reference model keeps the
// snake as a queue of visited cells (oldest first) plus a length; a cell's life
// is derived from its position in that queue.
module tb_snake_body_tracker;
   import snake_pkg::*;

   localparam int GW = 20;
   localparam int GH = 15;
   localparam int MAXL = 63;
   localparam int INITL = 3;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   snake_body_tracker_if #(.PXL_W(11), .LEN_W(6)) bus ();
   snake_body_tracker_if #(.PXL_W(11), .LEN_W(3)) sbus ();

   snake_body_tracker dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   snake_body_tracker #(.MAX_LEN(4)) dut_small (
      .clk   (clk),
      .reset (reset),
      .bus   (sbus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // ---------------- reference model ----------------
   int q_x[$];
   int q_y[$];
   int m_len;
   bit m_grow;
   bit m_dead;

   function automatic void m_reset();
      q_x.delete(); q_y.delete();
      q_x.push_back(1); q_y.push_back(1);
      m_len = INITL; m_grow = 0; m_dead = 0;
   endfunction

   function automatic int m_life(input int x, input int y);
      for (int i = 0; i < q_x.size(); i++)
         if (q_x[i] == x && q_y[i] == y) return m_len - (q_x.size() - 1 - i);
      return 0;
   endfunction

   task automatic m_step(input int d, input bit g_now, output bit e_done, output bit e_over);
      int nx, ny, v;
      bit g, off;
      e_done = 0; e_over = 1;
      if (!m_dead) begin
         g  = (m_grow || g_now) && (m_len < MAXL);
         nx = q_x[q_x.size()-1] + ((d == 1) ? 1 : 0) - ((d == 3) ? 1 : 0);
         ny = q_y[q_y.size()-1] + ((d == 2) ? 1 : 0) - ((d == 0) ? 1 : 0);
`ifdef SNAKE_WALL_WRAP_EN
         nx = (nx + GW) % GW;
         ny = (ny + GH) % GH;
         off = 0;
`else
         off = (nx < 0) || (nx >= GW) || (ny < 0) || (ny >= GH);
`endif
         v = off ? 0 : m_life(nx, ny);
         if (off || (g ? (v >= 1) : (v > 1))) begin
            m_dead = 1;
         end else begin
            if (g) m_len++;
            q_x.push_back(nx); q_y.push_back(ny);
            while (q_x.size() > m_len) begin
               void'(q_x.pop_front()); void'(q_y.pop_front());
            end
            m_grow = 0;
            e_done = 1; e_over = 0;
         end
      end
   endtask

   // ---------------- helpers ----------------
   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic probe(input int px, input int py, input bit eh, input bit eb, input string nm);
      bus.pxl_x = 11'(px); bus.pxl_y = 11'(py);
      tick();
      chk({nm, "_head"}, bus.draw_head, eh);
      chk({nm, "_body"}, bus.draw_body, eb);
   endtask

   // Full-grid comparison of draw flags against the model, one cell per cycle
   task automatic sweep(input string nm);
      int bad = 0;
      string first = "";
      bit eb, eh;
      for (int y = 0; y < GH; y++) begin
         for (int x = 0; x < GW; x++) begin
            bus.pxl_x = 11'(x * 32 + int'($urandom_range(0, 31)));
            bus.pxl_y = 11'(y * 32 + int'($urandom_range(0, 31)));
            tick();
            eh = (x == q_x[q_x.size()-1]) && (y == q_y[q_y.size()-1]);
            eb = (m_life(x, y) > 0) && !eh;
            if (bus.draw_body !== eb || bus.draw_head !== eh) begin
               if (bad == 0)
                  first = $sformatf("cell(%0d,%0d) got body=%0b head=%0b expected body=%0b head=%0b",
                                    x, y, bus.draw_body, bus.draw_head, eb, eh);
               bad++;
            end
         end
      end
      n_tests++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL %s: %0d cells differ, first %s", nm, bad, first);
      end
   endtask

   task automatic do_restart();
      bus.restart = 1; tick(); bus.restart = 0;
      m_reset();
      chk("restart_len", bus.length, INITL);
      chk("restart_gameover", bus.gameover, 0);
      chk("restart_busy", bus.busy, 0);
   endtask

   // One step with latency checks at t+1, t+2, t+3
   task automatic do_step(input int d, input bit g_now, input bit pre_grow,
                          output bit obs_done, output bit obs_over);
      bit e_done, e_over;
      if (pre_grow) begin
         bus.grow = 1; tick(); bus.grow = 0;
         if (!m_dead) m_grow = 1;
      end
      m_step(d, g_now, e_done, e_over);
      bus.step = 1; bus.dir = dir_t'(d); bus.grow = g_now;
      tick();
      bus.step = 0; bus.grow = 0;
      chk("busy_t1", bus.busy, 1);
      tick();
      obs_done = bus.step_done; obs_over = bus.gameover;
      chk("step_done_t2", bus.step_done, e_done);
      chk("gameover_t2", bus.gameover, e_over);
      chk("busy_t2", bus.busy, 1);
      tick();
      chk("busy_t3", bus.busy, m_dead);
      chk("step_done_t3", bus.step_done, 0);
      chk("length", bus.length, m_len);
      $display("[TB] step dir=%0d grow=%0b pre=%0b done=%0b over=%0b len=%0d",
               d, g_now, pre_grow, obs_done, obs_over, bus.length);
   endtask

   task automatic small_step(input bit pre_grow, input int exp_len, input string nm);
      if (pre_grow) begin sbus.grow = 1; tick(); sbus.grow = 0; end
      sbus.step = 1; sbus.dir = DIR_RIGHT; tick(); sbus.step = 0;
      tick();
      chk({nm, "_done"}, sbus.step_done, 1);
      tick();
      chk({nm, "_len"}, sbus.length, exp_len);
      $display("[TB] small step pre_grow=%0b len=%0d", pre_grow, sbus.length);
   endtask

   typedef struct {
      int d; bit pre; bit g;
      bit e_done; bit e_over; int e_len; int e_hx; int e_hy;
   } vec_t;

   vec_t tbl[9];

   initial begin
      bit od, oo;
      int dead_steps;

      tbl[0] = '{1, 0, 0, 1, 0, 3, 2, 1};
      tbl[1] = '{1, 0, 0, 1, 0, 3, 3, 1};
      tbl[2] = '{1, 0, 0, 1, 0, 3, 4, 1};
      tbl[3] = '{1, 1, 0, 1, 0, 4, 5, 1};   // grow pulse, then step right
      tbl[4] = '{2, 0, 0, 1, 0, 4, 5, 2};
      tbl[5] = '{3, 0, 0, 1, 0, 4, 4, 2};
      tbl[6] = '{0, 0, 0, 1, 0, 4, 4, 1};   // into the tail cell: legal
      tbl[7] = '{1, 0, 1, 0, 1, 4, 4, 1};   // into tail with grow: collision
      tbl[8] = '{2, 0, 0, 0, 1, 4, 4, 1};   // dead: step ignored

      bus.restart = 0; bus.step = 0; bus.dir = DIR_UP; bus.grow = 0;
      bus.pxl_x = 11'd40; bus.pxl_y = 11'd40;
      sbus.restart = 0; sbus.step = 0; sbus.dir = DIR_UP; sbus.grow = 0;
      sbus.pxl_x = '0; sbus.pxl_y = '0;
      m_reset();

      // Reset state
      repeat (3) tick();
      chk("rst_draw_head", bus.draw_head, 0);
      chk("rst_len", bus.length, INITL);
      chk("rst_busy", bus.busy, 0);
      chk("rst_gameover", bus.gameover, 0);
      chk("rst_step_done", bus.step_done, 0);
      reset = 0;
      tick();
      chk("init_draw_head", bus.draw_head, 1);
      chk("init_draw_body", bus.draw_body, 0);
      sweep("init_grid");

      // Directed table
      for (int i = 0; i < 9; i++) begin
         do_step(tbl[i].d, tbl[i].g, tbl[i].pre, od, oo);
         chk($sformatf("tbl%0d_done", i), od, tbl[i].e_done);
         chk($sformatf("tbl%0d_over", i), oo, tbl[i].e_over);
         chk($sformatf("tbl%0d_len", i), bus.length, tbl[i].e_len);
         probe(tbl[i].e_hx * 32, tbl[i].e_hy * 32, 1, 0, $sformatf("tbl%0d_hd_lo", i));
         probe(tbl[i].e_hx * 32 + 31, tbl[i].e_hy * 32 + 31, 1, 0, $sformatf("tbl%0d_hd_hi", i));
         sweep($sformatf("tbl%0d_grid", i));
      end
      probe(700, 40, 0, 0, "offgrid_x");
      probe(40, 480, 0, 0, "offgrid_y");
      do_restart();
      sweep("restart_grid");

      // Right wall
      for (int i = 0; i < 18; i++) do_step(1, 0, 0, od, oo);
      probe(19 * 32 + 5, 40, 1, 0, "wall_head");
      do_step(1, 0, 0, od, oo);
`ifdef SNAKE_WALL_WRAP_EN
      chk("wall_wrap_done", od, 1);
      chk("wall_wrap_over", oo, 0);
      probe(3, 40, 1, 0, "wrap_head");
`else
      chk("wall_done", od, 0);
      chk("wall_over", oo, 1);
`endif
      sweep("wall_grid");
      do_restart();

      // Steps during CHECK and COMMIT are dropped
      m_step(1, 0, od, oo);
      bus.step = 1; bus.dir = DIR_RIGHT; tick();
      bus.dir = DIR_DOWN; tick();
      chk("drop_step_done", bus.step_done, 1);
      tick();
      bus.step = 0;
      chk("drop_busy", bus.busy, 0);
      chk("drop_len", bus.length, INITL);
      sweep("drop_grid");

      // Restart during CHECK aborts the step
      do_step(1, 1, 0, od, oo);
      bus.step = 1; bus.dir = DIR_DOWN; tick();
      bus.restart = 1; tick();
      bus.restart = 0; bus.step = 0;
      m_reset();
      chk("abort_len", bus.length, INITL);
      chk("abort_gameover", bus.gameover, 0);
      chk("abort_step_done", bus.step_done, 0);
      chk("abort_busy", bus.busy, 0);
      sweep("abort_grid");

      // Randomized steps against the model
      dead_steps = 0;
      for (int i = 0; i < 70; i++) begin
         if (m_dead) begin
            if (dead_steps >= 1) begin
               do_restart();
               dead_steps = 0;
            end else begin
               dead_steps++;
            end
         end
         do_step(int'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 7) == 0), od, oo);
         sweep($sformatf("rand%0d_grid", i));
      end

      // Saturation on a MAX_LEN=4 instance
      sbus.restart = 1; tick(); sbus.restart = 0;
      chk("small_init_len", sbus.length, 3);
      for (int i = 0; i < 5; i++) small_step(1, 4, $sformatf("small%0d", i));
      sbus.pxl_x = 11'(6 * 32 + 7); sbus.pxl_y = 11'(40); tick();
      chk("small_head", sbus.draw_head, 1);
      sbus.pxl_x = 11'(5 * 32 + 7); tick();
      chk("small_body_5", sbus.draw_body, 1);
      sbus.pxl_x = 11'(2 * 32 + 7); tick();
      chk("small_empty_2", sbus.draw_body, 0);
      sbus.pxl_x = 11'd700; tick();
      chk("small_off_body", sbus.draw_body, 0);
      chk("small_off_head", sbus.draw_head, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
